// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: PC / IF/ID / ID/EX enables, flushes and bubbles.
// Handles load-use stalls, redirects and data-memory wait states; counts stall cycles.
module hazard_stall_controller #(
  parameter int RegAddrBits = 5,
  parameter int LoadStall   = 1,
  parameter int StatBits    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [RegAddrBits-1:0] IF_ID_Rs,
  input  logic [RegAddrBits-1:0] IF_ID_Rt,
  input  logic                   ID_Uses_Rt,
  input  logic                   ID_EX_MemRead,
  input  logic [RegAddrBits-1:0] ID_EX_Rt,
  input  logic                   Branch_Taken,
  input  logic                   Jump,
  input  logic                   Mem_Req,
  input  logic                   Mem_Ready,
  input  logic                   Stat_Clear,
  output logic                   PC_Write,
  output logic                   IF_ID_Write,
  output logic                   IF_ID_Flush,
  output logic                   ID_EX_Bubble,
  output logic                   Pipe_Hold,
  output logic [StatBits-1:0]    Stall_Cycles
);

  typedef enum logic [1:0] {
    RUN,
    LOAD_STALL,
    MEM_WAIT
  } state_t;

  localparam logic [2:0] LsInit = 3'(LoadStall - 1);

  state_t        r_state;
  state_t        w_next;
  logic [2:0]    r_cnt;
  logic [2:0]    w_cnt_next;
  logic [StatBits-1:0] r_stat;

  logic w_lu;
  logic w_mw;
  logic w_rd;

  assign w_lu = ID_EX_MemRead && (ID_EX_Rt != '0) &&
                ((ID_EX_Rt == IF_ID_Rs) ||
                 (ID_Uses_Rt && (ID_EX_Rt == IF_ID_Rt)));
  assign w_mw = Mem_Req && !Mem_Ready;
  assign w_rd = Branch_Taken || Jump;

  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    Pipe_Hold    = 1'b0;
    w_next       = r_state;
    w_cnt_next   = r_cnt;
    if (reset) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
      w_next       = RUN;
      w_cnt_next   = '0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (w_mw) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            Pipe_Hold   = 1'b1;
            w_next      = MEM_WAIT;
          end else if (w_lu) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            if (LoadStall > 1) begin
              w_next     = LOAD_STALL;
              w_cnt_next = LsInit;
            end
          end else if (w_rd) begin
            IF_ID_Flush = 1'b1;
          end
        end
        LOAD_STALL: begin
          PC_Write    = 1'b0;
          IF_ID_Write = 1'b0;
          if (w_mw) begin
            Pipe_Hold = 1'b1;
            w_next    = MEM_WAIT;
          end else begin
            ID_EX_Bubble = 1'b1;
            w_cnt_next   = r_cnt - 3'd1;
            if (r_cnt == 3'd1) w_next = RUN;
          end
        end
        MEM_WAIT: begin
          if (!Mem_Ready) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            Pipe_Hold   = 1'b1;
          end else begin
            // Release cycle behaves as RUN; an interrupted load stall resumes after it
            if (w_lu) begin
              PC_Write     = 1'b0;
              IF_ID_Write  = 1'b0;
              ID_EX_Bubble = 1'b1;
            end else if (w_rd) begin
              IF_ID_Flush = 1'b1;
            end
            w_next = (r_cnt != '0) ? LOAD_STALL : RUN;
          end
        end
        default: begin
          w_next     = RUN;
          w_cnt_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || Stat_Clear) begin
      r_stat <= '0;
    end else if (!PC_Write && (r_stat != '1)) begin
      r_stat <= r_stat + 1'b1;
    end
  end

  assign Stall_Cycles = r_stat;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: vector table, corner sequences, random vs model.
// Two instances share stimulus: LoadStall=1/16-bit stats and LoadStall=3/4-bit stats.
module tb_hazard_stall_controller;

  logic       clk;
  logic       reset;
  logic [4:0] rs, rt, xr;
  logic       ur, mr, br, jp, mq, my, clr;

  logic a_pc, a_ifw, a_fl, a_bb, a_ph;
  logic b_pc, b_ifw, b_fl, b_bb, b_ph;
  logic [15:0] a_sc;
  logic [3:0]  b_sc;

  hazard_stall_controller #(
    .RegAddrBits(5), .LoadStall(1), .StatBits(16)
  ) u_a (
    .clk(clk), .reset(reset),
    .IF_ID_Rs(rs), .IF_ID_Rt(rt), .ID_Uses_Rt(ur),
    .ID_EX_MemRead(mr), .ID_EX_Rt(xr),
    .Branch_Taken(br), .Jump(jp),
    .Mem_Req(mq), .Mem_Ready(my), .Stat_Clear(clr),
    .PC_Write(a_pc), .IF_ID_Write(a_ifw), .IF_ID_Flush(a_fl),
    .ID_EX_Bubble(a_bb), .Pipe_Hold(a_ph), .Stall_Cycles(a_sc)
  );

  hazard_stall_controller #(
    .RegAddrBits(5), .LoadStall(3), .StatBits(4)
  ) u_b (
    .clk(clk), .reset(reset),
    .IF_ID_Rs(rs), .IF_ID_Rt(rt), .ID_Uses_Rt(ur),
    .ID_EX_MemRead(mr), .ID_EX_Rt(xr),
    .Branch_Taken(br), .Jump(jp),
    .Mem_Req(mq), .Mem_Ready(my), .Stat_Clear(clr),
    .PC_Write(b_pc), .IF_ID_Write(b_ifw), .IF_ID_Flush(b_fl),
    .ID_EX_Bubble(b_bb), .Pipe_Hold(b_ph), .Stall_Cycles(b_sc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Hold}
  typedef struct packed {
    logic pc;
    logic ifw;
    logic fl;
    logic bb;
    logic ph;
  } ctl_t;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ur;
    logic       mr;
    logic [4:0] xr;
    logic       br;
    logic       jp;
    logic       mq;
    logic       my;
    logic       clr;
    logic [4:0] ctl;
    logic [15:0] sc;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: remaining load-stall cycles plus a "waiting on memory" flag
  bit   a_wt, b_wt;
  int   a_left, b_left;
  int   a_st, b_st;
  ctl_t ea, eb;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic bit m_lu();
    return mr && (xr != 0) && ((xr == rs) || (ur && (xr == rt)));
  endfunction

  function automatic ctl_t m_ctl(input bit wt, input int left);
    bit mw;
    mw = mq && !my;
    if (reset) return '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    if (wt && !my) return '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    if (!wt && left > 0) begin
      if (mw) return '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      return '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    end
    if (!wt && mw) return '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    if (m_lu()) return '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    if (br || jp) return '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    return '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  endfunction

  task automatic m_step(input int ls, inout bit wt, inout int left,
                        inout int st, input int mx, input bit pc);
    bit mw;
    mw = mq && !my;
    if (reset) begin
      wt = 0; left = 0; st = 0;
      return;
    end
    if (clr) st = 0;
    else if (!pc && st < mx) st = st + 1;
    if (wt) begin
      if (my) wt = 0;
    end else if (left > 0) begin
      if (mw) wt = 1;
      else left = left - 1;
    end else if (mw) begin
      wt = 1;
    end else if (m_lu()) begin
      left = ls - 1;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    ea = m_ctl(a_wt, a_left);
    eb = m_ctl(b_wt, b_left);
    chk("modelA", {11'd0, a_pc, a_ifw, a_fl, a_bb, a_ph, a_sc},
        {11'd0, ea, 16'(a_st)});
    chk("modelB", {23'd0, b_pc, b_ifw, b_fl, b_bb, b_ph, b_sc},
        {23'd0, eb, 4'(b_st)});
  endtask

  task automatic adv();
    @(posedge clk);
    m_step(1, a_wt, a_left, a_st, 65535, ea.pc);
    m_step(3, b_wt, b_left, b_st, 15, eb.pc);
    #1;
  endtask

  task automatic idle();
    reset = 0; rs = 0; rt = 0; ur = 0; mr = 0; xr = 0;
    br = 0; jp = 0; mq = 0; my = 0; clr = 0;
  endtask

  task automatic apply(input vec_t v);
    reset = v.rst; rs = v.rs; rt = v.rt; ur = v.ur; mr = v.mr;
    xr = v.xr; br = v.br; jp = v.jp; mq = v.mq; my = v.my; clr = v.clr;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    sample();
    adv();
    reset = 0;
  endtask

  vec_t tbl[19];
  logic exp_pc2[7];
  logic exp_ph2[7];

  initial begin
    tbl[0]  = '{1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00110, 16'd0};
    tbl[1]  = '{1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00110, 16'd0};
    tbl[2]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000, 16'd0};
    tbl[3]  = '{1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00010, 16'd0};
    tbl[4]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000, 16'd1};
    tbl[5]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000, 16'd1};
    tbl[6]  = '{1'b0, 5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000, 16'd1};
    tbl[7]  = '{1'b0, 5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00010, 16'd1};
    tbl[8]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11100, 16'd2};
    tbl[9]  = '{1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00010, 16'd2};
    tbl[10] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11100, 16'd3};
    tbl[11] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00001, 16'd3};
    tbl[12] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00001, 16'd4};
    tbl[13] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00001, 16'd5};
    tbl[14] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00001, 16'd6};
    tbl[15] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'b11000, 16'd7};
    tbl[16] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000, 16'd7};
    tbl[17] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b11000, 16'd7};
    tbl[18] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000, 16'd0};

    exp_pc2 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_ph2 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    a_wt = 0; b_wt = 0; a_left = 0; b_left = 0; a_st = 0; b_st = 0;
    ea = '0; eb = '0;
    idle();
    reset = 1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      apply(tbl[i]);
      sample();
      chk($sformatf("tbl%0d_ctl", i), {27'd0, a_pc, a_ifw, a_fl, a_bb, a_ph},
          {27'd0, tbl[i].ctl});
      chk($sformatf("tbl%0d_sc", i), {16'd0, a_sc}, {16'd0, tbl[i].sc});
      adv();
    end

    // LoadStall=3: one hazard gives three stall cycles
    do_reset();
    for (int c = 0; c < 4; c++) begin
      idle();
      if (c == 0) begin
        mr = 1; xr = 5'd8; rs = 5'd8;
      end
      sample();
      chk($sformatf("ls3_pc%0d", c), {31'd0, b_pc}, {31'd0, (c == 3)});
      if (c == 3) chk("ls3_sc", {28'd0, b_sc}, 32'd3);
      adv();
    end

    // LoadStall=3 with a two-cycle memory wait in the second stall cycle
    do_reset();
    for (int c = 0; c < 7; c++) begin
      idle();
      if (c == 0) begin
        mr = 1; xr = 5'd8; rs = 5'd8;
      end
      if (c >= 1 && c <= 3) mq = 1;
      if (c == 3) my = 1;
      sample();
      chk($sformatf("mix_pc%0d", c), {31'd0, b_pc}, {31'd0, exp_pc2[c]});
      chk($sformatf("mix_ph%0d", c), {31'd0, b_ph}, {31'd0, exp_ph2[c]});
      if (c == 6) chk("mix_sc", {28'd0, b_sc}, 32'd5);
      adv();
    end

    // Saturation on the 4-bit counter, then clear
    do_reset();
    for (int c = 0; c < 21; c++) begin
      idle();
      mq = 1;
      sample();
      adv();
    end
    idle();
    mq = 1;
    sample();
    chk("sat_b", {28'd0, b_sc}, 32'd15);
    chk("cnt_a", {16'd0, a_sc}, 32'd21);
    clr = 1;
    adv();
    clr = 0;
    sample();
    chk("clr_b", {28'd0, b_sc}, 32'd0);
    chk("clr_a", {16'd0, a_sc}, 32'd0);
    adv();

    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom % 64) == 0;
      rs    = 5'($urandom % 4);
      rt    = 5'($urandom % 4);
      xr    = 5'($urandom % 4);
      ur    = 1'($urandom % 2);
      mr    = 1'($urandom % 2);
      br    = ($urandom % 6) == 0;
      jp    = ($urandom % 8) == 0;
      mq    = ($urandom % 4) == 0;
      my    = ($urandom % 3) != 0;
      clr   = ($urandom % 50) == 0;
      sample();
      adv();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
